// File: rtl/pkt_tx_framer.sv
module pkt_tx_framer #(
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned MAX_WAIT     = 255
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  tx_setting,
  input  logic [2:0]            rPacketType,
  input  logic [5:0]            rTimeslot,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  input  logic                  channel_clear,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  tx_drop,
  output logic                  tx_overrun
);

  typedef enum logic [1:0] {IDLE, SENSE, SEND} state_t;

  localparam logic [3:0]  CLR_LAST  = 4'(CLEAR_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);
  localparam logic [3:0]  IDX_LAST  = 4'd8;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] word_q [0:7];
  logic [WORD_WIDTH-1:0] csum;
  logic [3:0]            clear_cnt_q;
  logic [15:0]           wait_cnt_q;
  logic [3:0]            idx_q;
  logic                  done_q, drop_q, ovr_q;
  logic                  sense_ok, sense_to, last_xfer;

  assign sense_ok  = channel_clear && (clear_cnt_q == CLR_LAST);
  assign sense_to  = wait_cnt_q == WAIT_LAST;
  assign last_xfer = tx_ready && (idx_q == IDX_LAST);

  always_ff @(posedge clk) begin
    if (nrst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tx_setting) state_d = SENSE;
      SENSE:   if (sense_ok) state_d = SEND;
               else if (sense_to) state_d = IDLE;
      SEND:    if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int unsigned i = 0; i < 8; i++) word_q[i] <= '0;
      clear_cnt_q <= '0;
      wait_cnt_q  <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      done_q <= (state_q == SEND) && last_xfer;
      drop_q <= (state_q == SENSE) && !sense_ok && sense_to;
      ovr_q  <= tx_setting && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (tx_setting) begin
            word_q[0]   <= WORD_WIDTH'({rPacketType, rTimeslot, 7'd8});
            word_q[1]   <= rDestinationID;
            word_q[2]   <= rSourceID;
            word_q[3]   <= rSourceHops;
            word_q[4]   <= rQValue;
            word_q[5]   <= rEnergyLeft;
            word_q[6]   <= rChosenCH;
            word_q[7]   <= rHopsFromCH;
            clear_cnt_q <= '0;
            wait_cnt_q  <= '0;
            idx_q       <= '0;
          end
        end
        SENSE: begin
          if (!channel_clear)       clear_cnt_q <= '0;
          else if (clear_cnt_q != '1) clear_cnt_q <= clear_cnt_q + 4'd1;
          if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 16'd1;
          idx_q <= '0;
        end
        SEND: begin
          if (tx_ready && (idx_q != IDX_LAST)) idx_q <= idx_q + 4'd1;
        end
        default: idx_q <= '0;
      endcase
    end
  end

  always_comb begin
    csum = '0;
    for (int unsigned i = 0; i < 8; i++) csum = csum + word_q[i];
  end

  always_comb begin
    busy     = (state_q != IDLE);
    tx_valid = 1'b0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    tx_data  = '0;
    if (state_q == SEND) begin
      tx_valid = 1'b1;
      tx_sop   = (idx_q == 4'd0);
      tx_eop   = (idx_q == IDX_LAST);
      tx_data  = (idx_q == IDX_LAST) ? csum : word_q[idx_q[2:0]];
    end
  end

  assign tx_done    = done_q;
  assign tx_drop    = drop_q;
  assign tx_overrun = ovr_q;

endmodule

// File: tb/tb_pkt_tx_framer.sv
module tb_pkt_tx_framer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        tx_setting;
  logic [2:0]  rPacketType;
  logic [5:0]  rTimeslot;
  logic [15:0] rDestinationID, rSourceID, rSourceHops, rQValue;
  logic [15:0] rEnergyLeft, rChosenCH, rHopsFromCH;
  logic        channel_clear, tx_ready;

  logic        tx_valid, tx_sop, tx_eop, busy, tx_done, tx_drop, tx_overrun;
  logic [15:0] tx_data;

  logic        d1_valid, d1_sop, d1_eop, d1_busy, d1_done, d1_drop, d1_ovr;
  logic [15:0] d1_data;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_w [0:8];

  always #5 clk = ~clk;

  pkt_tx_framer #(.WORD_WIDTH(16), .CLEAR_CYCLES(4), .MAX_WAIT(255)) dut (
    .clk(clk), .nrst(nrst), .tx_setting(tx_setting),
    .rPacketType(rPacketType), .rTimeslot(rTimeslot),
    .rDestinationID(rDestinationID), .rSourceID(rSourceID),
    .rSourceHops(rSourceHops), .rQValue(rQValue), .rEnergyLeft(rEnergyLeft),
    .rChosenCH(rChosenCH), .rHopsFromCH(rHopsFromCH),
    .channel_clear(channel_clear), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .busy(busy), .tx_done(tx_done), .tx_drop(tx_drop), .tx_overrun(tx_overrun)
  );

  pkt_tx_framer #(.WORD_WIDTH(16), .CLEAR_CYCLES(4), .MAX_WAIT(10)) dut_to (
    .clk(clk), .nrst(nrst), .tx_setting(tx_setting),
    .rPacketType(rPacketType), .rTimeslot(rTimeslot),
    .rDestinationID(rDestinationID), .rSourceID(rSourceID),
    .rSourceHops(rSourceHops), .rQValue(rQValue), .rEnergyLeft(rEnergyLeft),
    .rChosenCH(rChosenCH), .rHopsFromCH(rHopsFromCH),
    .channel_clear(channel_clear), .tx_ready(tx_ready),
    .tx_valid(d1_valid), .tx_data(d1_data), .tx_sop(d1_sop), .tx_eop(d1_eop),
    .busy(d1_busy), .tx_done(d1_done), .tx_drop(d1_drop), .tx_overrun(d1_ovr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fields(input bit garbage);
    if (garbage) begin
      rPacketType = 3'b111; rTimeslot = 6'h3F;
      rDestinationID = 16'hDEAD; rSourceID = 16'hBEEF; rSourceHops = 16'h1234;
      rQValue = 16'h5555; rEnergyLeft = 16'hAAAA; rChosenCH = 16'hFFFF; rHopsFromCH = 16'h7777;
    end else begin
      rPacketType = 3'b010; rTimeslot = 6'd5;
      rDestinationID = 16'h0001; rSourceID = 16'h0007; rSourceHops = 16'h0002;
      rQValue = 16'h0100; rEnergyLeft = 16'h03E8; rChosenCH = 16'h0004; rHopsFromCH = 16'h0001;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b1; tx_setting = 1'b0; channel_clear = 1'b1; tx_ready = 1'b1;
    tick();
    tick();
    nrst = 1'b0;
  endtask

  // called in cycle T; returns in T+1 with the strobe dropped
  task automatic start_pkt();
    load_fields(1'b0);
    tx_setting = 1'b1;
    tick();
    tx_setting = 1'b0;
  endtask

  // called at T+1; returns at T+5
  task automatic sense_wait(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_sense_valid"}, 32'(tx_valid), 32'd0);
      check({tag, "_sense_busy"}, 32'(busy), 32'd1);
      tick();
    end
  endtask

  // called in the cycle word 0 is expected; returns in the tx_done cycle
  task automatic frame(input string tag, input int stall_word, input int stall_len, input int ovr_word);
    int   widx = 0;
    int   stalls = 0;
    int   n = 0;
    bit   ovr_sent = 0;
    logic prev_set = 1'b0;
    while (widx < 9 && n < 40) begin
      check({tag, "_valid"}, 32'(tx_valid), 32'd1);
      check({tag, "_data"}, 32'(tx_data), 32'(exp_w[widx]));
      check({tag, "_sop"}, 32'(tx_sop), 32'(widx == 0));
      check({tag, "_eop"}, 32'(tx_eop), 32'(widx == 8));
      check({tag, "_ovr"}, 32'(tx_overrun), 32'(prev_set));
      tx_setting = 1'b0;
      prev_set = 1'b0;
      if (widx == ovr_word && !ovr_sent) begin
        load_fields(1'b1);
        tx_setting = 1'b1;
        ovr_sent = 1;
        prev_set = 1'b1;
      end
      if (widx == stall_word && stalls < stall_len) begin
        tx_ready = 1'b0;
        stalls++;
      end else begin
        tx_ready = 1'b1;
        widx++;
      end
      tick();
      n++;
    end
    tx_setting = 1'b0;
    tx_ready = 1'b1;
    check({tag, "_words"}, 32'(widx), 32'd9);
    check({tag, "_done"}, 32'(tx_done), 32'd1);
    check({tag, "_end_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_ovr"}, 32'(tx_overrun), 32'(prev_set));
  endtask

  initial begin
    exp_w[0] = 16'h4288; exp_w[1] = 16'h0001; exp_w[2] = 16'h0007;
    exp_w[3] = 16'h0002; exp_w[4] = 16'h0100; exp_w[5] = 16'h03E8;
    exp_w[6] = 16'h0004; exp_w[7] = 16'h0001; exp_w[8] = 16'h477F;
    load_fields(1'b0);

    // reset state
    do_reset();
    check("rst_flags", 32'({busy, tx_valid, tx_sop, tx_eop, tx_done, tx_drop, tx_overrun}), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);

    // nominal, with inputs scrambled after capture
    start_pkt();
    load_fields(1'b1);
    sense_wait("nom");
    frame("nom", -1, 0, -1);
    tick();
    check("nom_done_pulse", 32'(tx_done), 32'd0);

    // sense restart
    do_reset();
    begin
      logic [7:0] pat;
      pat = 8'b1111_0111;
      start_pkt();
      for (int i = 0; i < 8; i++) begin
        channel_clear = pat[i];
        check("restart_valid", 32'(tx_valid), 32'd0);
        tick();
      end
      channel_clear = 1'b1;
      frame("restart", -1, 0, -1);
    end

    // timeout on the MAX_WAIT=10 instance
    do_reset();
    channel_clear = 1'b0;
    start_pkt();
    for (int i = 1; i <= 10; i++) begin
      check("to_drop_early", 32'(d1_drop), 32'd0);
      check("to_valid", 32'(d1_valid), 32'd0);
      tick();
    end
    check("to_drop", 32'(d1_drop), 32'd1);
    check("to_busy", 32'(d1_busy), 32'd0);
    check("to_long_busy", 32'(busy), 32'd1);
    check("to_long_drop", 32'(tx_drop), 32'd0);
    tick();
    check("to_drop_pulse", 32'(d1_drop), 32'd0);
    check("to_valid_after", 32'(d1_valid), 32'd0);

    // backpressure during word 4
    do_reset();
    start_pkt();
    sense_wait("bp");
    frame("bp", 4, 3, -1);

    // overrun during SEND, then back-to-back start in the done cycle
    do_reset();
    start_pkt();
    sense_wait("ov");
    frame("ov", -1, 0, 2);
    start_pkt();
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_ovr", 32'(tx_overrun), 32'd0);
    check("b2b_done_pulse", 32'(tx_done), 32'd0);
    sense_wait("b2b");
    frame("b2b", -1, 0, -1);

    // reset during word 3
    do_reset();
    start_pkt();
    sense_wait("mr");
    for (int i = 0; i < 3; i++) tick();
    check("mr_word3", 32'(tx_data), 32'h0002);
    nrst = 1'b1;
    tick();
    nrst = 1'b0;
    check("mr_flags", 32'({busy, tx_valid, tx_sop, tx_eop, tx_done, tx_drop, tx_overrun}), 32'd0);
    check("mr_data", 32'(tx_data), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("mr_no_done", 32'(tx_done), 32'd0);
      check("mr_idle", 32'(busy), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
